fifo_read_ctrl: RTL and testbench

Read-side controller for the team's async FIFO, running entirely in the read clock domain. It owns the read pointer and synchronizes the write domain's Gray-coded write pointer. It computes empty and occupancy, drives the read port (rd_en, read_addr) of the dual-clock memory, and presents popped data on a first-word-fall-through valid/ready interface. Its write-domain counterpart consumes rptr_gray to derive full.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/fifo_read_ctrl.sv | 86 ++++++++
 tb/tb_fifo_read_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: default geometry and Gray/binary pointer conversion.
// Latency: n/a (pure constants and combinational functions).
// Backpressure: n/a.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;

  // Functions work on a 32-bit container. Callers zero-extend narrower
  // pointers going in and size-cast the result back coming out. Leading
  // zeros do not change either conversion, so a truncated result is exact.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the clk domain.
// Latency: 2 clk edges from d to q.
// Backpressure: none; samples every cycle.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Plain back-to-back flops with no logic between them, so the first stage has a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Async FIFO read-side controller: read pointer, write-pointer sync, empty/avail, FWFT output stage.
// Latency: wptr_gray change to out_valid is 3 clk_rd edges minimum; 1 word/cycle sustained.
// Backpressure: out_valid && !out_ready stalls fetching; mem_read_data (and out_data) then holds.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_rd,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   avail
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] wq2;
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray;
  logic [PTR_W-1:0] rgray_next;
  logic             fetch;

  // wq2 is the only view of the write pointer in this domain.
  sync_2ff #(
    .WIDTH (PTR_W)
  ) u_wptr_sync (
    .clk   (clk_rd),
    .rst_n (rst_n),
    .d     (wptr_gray),
    .q     (wq2)
  );

  // Status comes only from registers (wq2, rgray, rbin). The raw async wptr_gray never reaches an output.
  assign wbin  = PTR_W'(gray2bin(32'(wq2)));
  assign empty = (rgray == wq2);
  assign avail = wbin - rbin;

  // Fetch when memory holds a word and the output slot is free or is draining this cycle.
  assign fetch     = !empty && (!out_valid || out_ready);
  assign rd_en     = fetch;
  assign read_addr = rbin[ADDR_WIDTH-1:0];
  assign out_data  = mem_read_data;
  assign rptr_gray = rgray;

  // The extra MSB lets the pointer wrap naturally and distinguishes full from empty on the write side.
  assign rbin_next  = fetch ? rbin + PTR_W'(1) : rbin;
  assign rgray_next = PTR_W'(bin2gray(32'(rbin_next)));

  // Binary and Gray read pointers advance together, one step per fetch.
  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      rbin  <= '0;
      rgray <= '0;
    end else begin
      rbin  <= rbin_next;
      rgray <= rgray_next;
    end
  end

  // The output slot fills on a fetch (the memory presents the word next cycle) and empties on a pop without a refill.
  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (fetch) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // The write domain relies on a single-bit change per step to sample rptr_gray safely.
  assert property (@(posedge clk_rd) disable iff (!rst_n)
                   $countones(rgray ^ $past(rgray)) <= 1);

endmodule

// File: tb/tb_fifo_read_ctrl.sv
`timescale 1ns/1ps
module tb_fifo_read_ctrl;

  logic       clk_rd = 1'b0;
  logic       rst_n  = 1'b1;
  logic [4:0] wptr_gray = '0;
  logic [4:0] rptr_gray;
  logic       rd_en;
  logic [3:0] read_addr;
  logic [7:0] mem_read_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       empty;
  logic [4:0] avail;

  logic [7:0]  mem [16];
  logic [24:0] obs_vec;
  int total = 0;
  int bad   = 0;

  always #5 clk_rd = ~clk_rd;

  fifo_read_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk_rd        (clk_rd),
    .rst_n         (rst_n),
    .wptr_gray     (wptr_gray),
    .rptr_gray     (rptr_gray),
    .rd_en         (rd_en),
    .read_addr     (read_addr),
    .mem_read_data (mem_read_data),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .empty         (empty),
    .avail         (avail)
  );

  // Registered-read memory model: data updates the cycle after rd_en and holds otherwise.
  always @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) mem_read_data <= '0;
    else if (rd_en) mem_read_data <= mem[read_addr];
  end

  assign obs_vec = {empty, avail, rd_en, read_addr, out_valid, rptr_gray, out_data};

  typedef struct {
    logic [4:0]  wptr;
    logic        rdy;
    logic [24:0] exp;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [24:0] pack(input logic e, input logic [4:0] av, input logic rd,
                                       input logic [3:0] ad, input logic ov, input logic [4:0] rp,
                                       input logic [7:0] dat);
    return {e, av, rd, ad, ov, rp, dat};
  endfunction

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] t;
    t = 5'(b);
    return t ^ (t >> 1);
  endfunction

  function automatic logic [7:0] wdata(input int k);
    return 8'(k * 37 + 5);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [4:0] w);
    @(negedge clk_rd);
    rst_n = 1'b0;
    wptr_gray = w;
    out_ready = 1'b1;
    repeat (2) @(negedge clk_rd);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wcount, consumed, fetched, cyc;
    logic [4:0] prev_rptr;
    bit saw_aw, saw_pw;

    // Single-entry then backpressure sequence; cols: wptr, rdy | empty, avail, rd_en, addr, ov, rptr, data
    tbl[0]  = '{5'd1, 1'b1, pack(1'b1, 5'd0, 1'b0, 4'd0, 1'b0, 5'd0, 8'h00)};
    tbl[1]  = '{5'd1, 1'b1, pack(1'b1, 5'd0, 1'b0, 4'd0, 1'b0, 5'd0, 8'h00)};
    tbl[2]  = '{5'd1, 1'b1, pack(1'b0, 5'd1, 1'b1, 4'd0, 1'b0, 5'd0, 8'h00)};
    tbl[3]  = '{5'd1, 1'b1, pack(1'b1, 5'd0, 1'b0, 4'd1, 1'b1, 5'd1, 8'h30)};
    tbl[4]  = '{5'd6, 1'b0, pack(1'b1, 5'd0, 1'b0, 4'd1, 1'b0, 5'd1, 8'h30)};
    tbl[5]  = '{5'd6, 1'b0, pack(1'b1, 5'd0, 1'b0, 4'd1, 1'b0, 5'd1, 8'h30)};
    tbl[6]  = '{5'd6, 1'b0, pack(1'b0, 5'd3, 1'b1, 4'd1, 1'b0, 5'd1, 8'h30)};
    tbl[7]  = '{5'd6, 1'b0, pack(1'b0, 5'd2, 1'b0, 4'd2, 1'b1, 5'd3, 8'h31)};
    tbl[8]  = '{5'd6, 1'b0, pack(1'b0, 5'd2, 1'b0, 4'd2, 1'b1, 5'd3, 8'h31)};
    tbl[9]  = '{5'd6, 1'b1, pack(1'b0, 5'd2, 1'b1, 4'd2, 1'b1, 5'd3, 8'h31)};
    tbl[10] = '{5'd6, 1'b1, pack(1'b0, 5'd1, 1'b1, 4'd3, 1'b1, 5'd2, 8'h32)};
    tbl[11] = '{5'd6, 1'b1, pack(1'b1, 5'd0, 1'b0, 4'd4, 1'b1, 5'd6, 8'h33)};
    tbl[12] = '{5'd6, 1'b1, pack(1'b1, 5'd0, 1'b0, 4'd4, 1'b0, 5'd6, 8'h33)};

    for (int k = 0; k < 16; k++) mem[k] = 8'h00;

    // Reset state with a non-zero write pointer present at the input.
    #2;
    rst_n = 1'b0;
    wptr_gray = 5'b00011;
    out_ready = 1'b1;
    @(negedge clk_rd);
    @(negedge clk_rd);
    #1;
    chk("reset_state", 32'(obs_vec), 32'(pack(1'b1, 5'd0, 1'b0, 4'd0, 1'b0, 5'd0, 8'h00)));
    @(negedge clk_rd);
    rst_n = 1'b1;
    n = 0;
    while (n < 8 && !out_valid) begin
      @(posedge clk_rd);
      #1;
      n++;
    end
    chk("ov_latency", 32'(n), 32'd3);

    // Table-driven single-entry and backpressure vectors.
    for (int k = 0; k < 16; k++) mem[k] = 8'(8'h30 + k);
    do_reset(5'd0);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk_rd);
      wptr_gray = tbl[i].wptr;
      out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl[%0d]", i), 32'(obs_vec), 32'(tbl[i].exp));
    end

    // Full-depth burst: 16 back-to-back fetches.
    for (int k = 0; k < 16; k++) mem[k] = 8'(8'h80 + k);
    do_reset(5'd0);
    @(negedge clk_rd);
    wptr_gray = gray5(16);
    out_ready = 1'b1;
    #1;
    n = 0;
    while (!rd_en && n < 6) begin
      @(negedge clk_rd);
      #1;
      n++;
    end
    chk("burst_lat", 32'(n), 32'd2);
    for (int i = 0; i < 18; i++) begin
      logic [24:0] e;
      if (i > 0) begin
        @(negedge clk_rd);
        #1;
      end
      if (i < 16)
        e = pack(1'b0, 5'(16 - i), 1'b1, 4'(i), i > 0, gray5(i), (i > 0) ? 8'(8'h80 + i - 1) : 8'h00);
      else if (i == 16)
        e = pack(1'b1, 5'd0, 1'b0, 4'd0, 1'b1, gray5(16), 8'h8F);
      else
        e = pack(1'b1, 5'd0, 1'b0, 4'd0, 1'b0, gray5(16), 8'h8F);
      chk($sformatf("burst[%0d]", i), 32'(obs_vec), 32'(e));
    end

    // Asynchronous reset while a word is being presented.
    do_reset(5'd0);
    @(negedge clk_rd);
    wptr_gray = gray5(8);
    out_ready = 1'b1;
    #1;
    n = 0;
    while (!out_valid && n < 8) begin
      @(negedge clk_rd);
      #1;
      n++;
    end
    chk("mid_ov", 32'(out_valid), 32'd1);
    chk("mid_rptr_pre", 32'(rptr_gray), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_reset", 32'(obs_vec), 32'(pack(1'b1, 5'd0, 1'b0, 4'd0, 1'b0, 5'd0, 8'h00)));
    @(negedge clk_rd);
    wptr_gray = 5'd0;
    @(negedge clk_rd);
    rst_n = 1'b1;

    // 40 entries through depth 16 with intermittent consumer stalls.
    wcount = 0; consumed = 0; fetched = 0; cyc = 0;
    prev_rptr = 5'd0; saw_aw = 0; saw_pw = 0;
    while (consumed < 40 && cyc < 600) begin
      @(negedge clk_rd);
      out_ready = (cyc % 5) != 3;
      if (wcount < 40 && (wcount - consumed) < 16) begin
        mem[4'(wcount)] = wdata(wcount);
        wcount++;
        wptr_gray = gray5(wcount);
      end
      #1;
      chk("rptr_step", 32'($countones(rptr_gray ^ prev_rptr) <= 1), 32'd1);
      if (prev_rptr == 5'b10000 && rptr_gray == 5'b00000) saw_pw = 1;
      prev_rptr = rptr_gray;
      if (rd_en) begin
        chk("wrap_addr", 32'(read_addr), 32'(fetched % 16));
        if (fetched % 16 == 0 && fetched > 0) saw_aw = 1;
        fetched++;
      end
      if (out_valid && out_ready) begin
        chk("wrap_data", 32'(out_data), 32'(wdata(consumed)));
        consumed++;
      end
      cyc++;
    end
    chk("wrap_count", 32'(consumed), 32'd40);
    chk("addr_wrap_seen", 32'(saw_aw), 32'd1);
    chk("ptr_wrap_seen", 32'(saw_pw), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
